// File: rtl/register_file_8x16_if.sv
// Bus bundle for the 8x16 register file: two read ports, the general write
// port, and the dedicated PC (R7) write/view port.
interface register_file_8x16_if #(
    parameter int DATA_W = 16
);
    logic [2:0]        rd_addr_a;
    logic [2:0]        rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              wr_en;
    logic [2:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              pc_wr_en;
    logic [DATA_W-1:0] pc_in;
    logic [DATA_W-1:0] pc_out;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, pc_wr_en, pc_in,
        input  rd_data_a, rd_data_b, pc_out
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, pc_wr_en, pc_in,
        output rd_data_a, rd_data_b, pc_out
    );
endinterface

// File: rtl/register_file_8x16.sv
// Eight 16-bit registers (R7 = PC) with two combinational read ports.
// Optional REGFILE_WR_BYPASS_EN forwards same-cycle writes to the read ports.
module register_file_8x16 #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    register_file_8x16_if.slave  bus
);
    localparam logic [2:0] PC_IDX = 3'd7;

    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;

    // Register array update; the general port is applied last so it wins on R7.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (bus.pc_wr_en) begin
                regs_r[PC_IDX] <= bus.pc_in;
            end
            if (bus.wr_en) begin
                regs_r[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

`ifdef REGFILE_WR_BYPASS_EN
    // Read port A with forwarding; gated by rst_n so reset always reads zero.
    always_comb begin
        rd_a_s = regs_r[bus.rd_addr_a];
        if (rst_n && bus.wr_en && (bus.rd_addr_a == bus.wr_addr)) begin
            rd_a_s = bus.wr_data;
        end else if (rst_n && bus.pc_wr_en && (bus.rd_addr_a == PC_IDX)) begin
            rd_a_s = bus.pc_in;
        end else begin
            rd_a_s = regs_r[bus.rd_addr_a];
        end
    end

    // Read port B with forwarding, same priority as port A.
    always_comb begin
        rd_b_s = regs_r[bus.rd_addr_b];
        if (rst_n && bus.wr_en && (bus.rd_addr_b == bus.wr_addr)) begin
            rd_b_s = bus.wr_data;
        end else if (rst_n && bus.pc_wr_en && (bus.rd_addr_b == PC_IDX)) begin
            rd_b_s = bus.pc_in;
        end else begin
            rd_b_s = regs_r[bus.rd_addr_b];
        end
    end
`else
    // Plain stored-value reads on both ports.
    always_comb begin
        rd_a_s = regs_r[bus.rd_addr_a];
        rd_b_s = regs_r[bus.rd_addr_b];
    end
`endif

    assign bus.rd_data_a = rd_a_s;
    assign bus.rd_data_b = rd_b_s;
    // The PC view is never forwarded, so fetch logic sees a stable value all cycle.
    assign bus.pc_out    = regs_r[PC_IDX];

endmodule

// File: tb/tb_register_file_8x16.sv
// Scoreboard bench: stimulus queues expected read values, a negedge monitor
// pops and compares them against the DUT outputs.
module tb_register_file_8x16;
    logic clk;
    logic rst_n;

    register_file_8x16_if #(.DATA_W(16)) bus ();

    register_file_8x16 #(.DATA_W(16), .NUM_REGS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        int          sel;   // 0 = rd_data_a, 1 = rd_data_b, 2 = pc_out
        logic [15:0] exp;
    } chk_t;

    chk_t q[$];
    int   total = 0;
    int   bad   = 0;

`ifdef REGFILE_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are combinational, so sample mid-cycle at the negedge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            chk_t c;
            logic [15:0] act;
            c = q.pop_front();
            case (c.sel)
                0:       act = bus.rd_data_a;
                1:       act = bus.rd_data_b;
                default: act = bus.pc_out;
            endcase
            total++;
            if (act !== c.exp) begin
                bad++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    task automatic push(input string name, input int sel, input logic [15:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        q.push_back(c);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en    = 1'b0;
        bus.pc_wr_en = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask

    task automatic pcw(input logic [15:0] d);
        bus.pc_wr_en = 1'b1;
        bus.pc_in    = d;
    endtask

    logic [15:0] sweep_exp [8];

    initial begin
        rst_n         = 1'b0;
        bus.rd_addr_a = 3'd0;
        bus.rd_addr_b = 3'd7;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = 3'd0;
        bus.wr_data   = 16'h0000;
        bus.pc_wr_en  = 1'b0;
        bus.pc_in     = 16'h0000;
        #1;
        push("reset_a", 0, 16'h0000);
        push("reset_b", 1, 16'h0000);
        push("reset_pc", 2, 16'h0000);
        cyc();

        // Writes during reset must be ignored, even pre-edge with forwarding.
        wr(3'd1, 16'h1111);
        pcw(16'h2222);
        bus.rd_addr_a = 3'd1;
        push("rst_wr_ignored_a", 0, 16'h0000);
        push("rst_wr_ignored_b", 1, 16'h0000);
        push("rst_wr_ignored_pc", 2, 16'h0000);
        cyc();
        idle();
        push("rst_wr_lost", 0, 16'h0000);
        cyc();

        // First edge after release accepts a write.
        rst_n = 1'b1;
        wr(3'd1, 16'h1111);
        cyc();
        idle();
        push("first_write", 0, 16'h1111);
        cyc();

        wr(3'd2, 16'hBEEF);
        cyc();
        idle();
        bus.rd_addr_a = 3'd2;
        bus.rd_addr_b = 3'd2;
        push("same_reg_a", 0, 16'hBEEF);
        push("same_reg_b", 1, 16'hBEEF);
        cyc();

        wr(3'd7, 16'h0040);
        pcw(16'h0011);
        cyc();
        idle();
        bus.rd_addr_a = 3'd7;
        push("r7_prio_pc", 2, 16'h0040);
        push("r7_prio_a", 0, 16'h0040);
        cyc();

        wr(3'd4, 16'hA5A5);
        pcw(16'h0002);
        cyc();
        idle();
        bus.rd_addr_a = 3'd4;
        bus.rd_addr_b = 3'd7;
        push("dual_wr_r4", 0, 16'hA5A5);
        push("dual_wr_pc", 2, 16'h0002);
        push("dual_wr_r7", 1, 16'h0002);
        cyc();

        // pc_out is never forwarded.
        pcw(16'h0100);
        push("pc_no_bypass", 2, 16'h0002);
        cyc();
        idle();
        push("pc_only_wr", 2, 16'h0100);
        cyc();

        wr(3'd5, 16'h0001);
        cyc();
        wr(3'd5, 16'h00FF);
        bus.rd_addr_b = 3'd5;
        push("bypass_r5_pre", 1, BYP ? 16'h00FF : 16'h0001);
        cyc();
        idle();
        push("r5_post", 1, 16'h00FF);
        cyc();

        wr(3'd7, 16'h0777);
        pcw(16'h0888);
        bus.rd_addr_a = 3'd7;
        push("bypass_r7_prio", 0, BYP ? 16'h0777 : 16'h0100);
        push("bypass_r7_pc", 2, 16'h0100);
        cyc();
        idle();
        push("r7_prio_post", 2, 16'h0777);
        cyc();

        pcw(16'h0999);
        push("bypass_pc_in", 0, BYP ? 16'h0999 : 16'h0777);
        cyc();
        idle();
        push("pc_in_post", 0, 16'h0999);
        cyc();

        sweep_exp[0] = 16'h0000;
        sweep_exp[1] = 16'h1111;
        sweep_exp[2] = 16'hBEEF;
        sweep_exp[3] = 16'h0000;
        sweep_exp[4] = 16'hA5A5;
        sweep_exp[5] = 16'h00FF;
        sweep_exp[6] = 16'h0000;
        sweep_exp[7] = 16'h0999;
        for (int i = 0; i < 10; i++) begin
            bus.rd_addr_a = 3'(i % 8);
            bus.rd_addr_b = 3'(7 - (i % 8));
            push($sformatf("hold_a%0d", i % 8), 0, sweep_exp[i % 8]);
            push($sformatf("hold_b%0d", 7 - (i % 8)), 1, sweep_exp[7 - (i % 8)]);
            cyc();
        end

        // Mid-cycle async reset: checked at the negedge, before any rising edge.
        wr(3'd3, 16'h1234);
        cyc();
        idle();
        bus.rd_addr_a = 3'd3;
        bus.rd_addr_b = 3'd6;
        push("r3_loaded", 0, 16'h1234);
        cyc();
        #1;
        rst_n = 1'b0;
        wr(3'd6, 16'h6666);
        push("async_rst_a", 0, 16'h0000);
        push("async_rst_pc", 2, 16'h0000);
        push("async_rst_wr_b", 1, 16'h0000);
        cyc();
        idle();
        rst_n = 1'b1;
        push("rst_coincide_lost", 1, 16'h0000);
        cyc();

        for (int k = 0; k < 20 && q.size() > 0; k++) begin
            @(negedge clk);
        end
        #1;
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d checks unconsumed, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/register_file_8x16.md
REGISTER_FILE_8X16 -- requirements
Module: register_file_8x16

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, which sets the register and data-port width; only 16 is supported.
REQ-002 The block SHALL have parameter NUM_REGS, default 8, which sets the register count; the address width SHALL be 3.
REQ-003 The block SHALL have port clk, input, width 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, width 1, an asynchronous active-low reset.
REQ-005 The block SHALL have port rd_addr_a, input, width 3, the read port A register index.
REQ-006 The block SHALL have port rd_addr_b, input, width 3, the read port B register index.
REQ-007 The block SHALL have port rd_data_a, output, width 16, the contents of register rd_addr_a; it feeds operand mux input A0.
REQ-008 The block SHALL have port rd_data_b, output, width 16, the contents of register rd_addr_b; it feeds operand mux input A1.
REQ-009 The block SHALL have port wr_en, input, width 1, the general write enable.
REQ-010 The block SHALL have port wr_addr, input, width 3, the general write index.
REQ-011 The block SHALL have port wr_data, input, width 16, the general write data.
REQ-012 The block SHALL have port pc_wr_en, input, width 1, the dedicated R7 (PC) write enable.
REQ-013 The block SHALL have port pc_in, input, width 16, the dedicated R7 write data.
REQ-014 The block SHALL have port pc_out, output, width 16, a continuous view of R7.

Function
REQ-015 The block SHALL hold eight 16-bit registers, R0 to R7; R7 is the program counter.
REQ-016 Reads SHALL be combinational: rd_data_a, rd_data_b and pc_out SHALL reflect stored contents in the same cycle as the address change, with zero clock latency.
REQ-017 When wr_en=1 at a rising clk edge, R[wr_addr] SHALL be loaded with wr_data, and the new value SHALL be visible on the read ports after that edge.
REQ-018 When pc_wr_en=1 at a rising clk edge, R7 SHALL be loaded with pc_in.
REQ-019 When wr_en=1, wr_addr=7 and pc_wr_en=1 in the same cycle, the general write port SHALL win and R7 SHALL take wr_data (a branch result overrides the PC increment).
REQ-020 When wr_en=1 and pc_wr_en=1 with wr_addr!=7, both writes SHALL take effect on the same edge.
REQ-021 Registers not addressed by an active write SHALL hold their value.
REQ-022 Both read ports SHALL be permitted to address the same register, each returning identical data.
REQ-023 The block SHALL produce no X on any output after reset for any input combination, and no latches SHALL be inferred.

Reset
REQ-024 When rst_n=0, all eight registers SHALL clear to 16'h0000 immediately, regardless of clk.
REQ-025 While rst_n=0, rd_data_a, rd_data_b and pc_out SHALL read 16'h0000, and writes SHALL be ignored.
REQ-026 A write coinciding with reset assertion SHALL be lost, and the register SHALL read 0.
REQ-027 The first write SHALL be accepted on the first rising clk edge after rst_n deasserts.

Configuration
REQ-028 Macro REGFILE_WR_BYPASS_EN SHALL control same-cycle write-to-read forwarding.
REQ-029 With REGFILE_WR_BYPASS_EN defined: if wr_en=1 and rd_addr_x equals wr_addr, rd_data_x SHALL equal wr_data combinationally in that cycle; otherwise (pc_wr_en=1, no general write to R7) a read of R7 SHALL return pc_in. The REQ-019 priority SHALL also apply to the bypass.
REQ-030 Without REGFILE_WR_BYPASS_EN: reads SHALL return pre-edge stored contents, and pc_out SHALL never be bypassed in either build.

Verification
REQ-031 Assert rst_n=0 mid-cycle after loading R3=16'h1234 -> R3, rd_data_a and pc_out read 16'h0000 without waiting for a clk edge.
REQ-032 Write R2=16'hBEEF, then rd_addr_a=2 and rd_addr_b=2 -> both ports read 16'hBEEF the cycle after the write edge.
REQ-033 Set wr_en=1, wr_addr=7, wr_data=16'h0040, pc_wr_en=1, pc_in=16'h0011 -> pc_out=16'h0040 after the edge.
REQ-034 Set wr_en=1, wr_addr=4, wr_data=16'hA5A5 with pc_wr_en=1, pc_in=16'h0002 -> R4=16'hA5A5 and R7=16'h0002 after one edge.
REQ-035 With R5=16'h0001, write wr_addr=5, wr_data=16'h00FF and rd_addr_b=5 in the same cycle -> rd_data_b=16'h00FF pre-edge with the macro, and 16'h0001 pre-edge without it.
REQ-036 Hold wr_en=0 for 10 cycles while sweeping read addresses 0 to 7 -> all read values stay unchanged.
